// File: rtl/ascii_num_parser.sv
// ascii_num_parser
// -----------------------------------------------------------------------------
// Converts a raw ASCII byte stream into binary integers, one byte per cycle.
// Each maximal run of decimal digits, optionally preceded by a '-' when
// ALLOW_NEG is set, becomes one output word. Every other byte is a delimiter.
// The delimiter that ended a number is reported with it.
//
// Parameters
//   W          output integer width in bits
//   ALLOW_NEG  1 = a '-' directly before the first digit negates the number
//
// Ports
//   clock         system clock
//   reset         asynchronous, active-high reset
//   in_valid      input byte valid
//   in_ready      parser accepts a byte this cycle
//   in_data       ASCII byte
//   in_last       final byte of the input file
//   out_valid     out_num valid
//   out_ready     consumer accepts out_num
//   out_num       parsed value (two's complement when negated)
//   out_delim     byte that ended the number (8'h00 if ended by in_last on a digit)
//   out_overflow  magnitude exceeded W bits; out_num holds the low W bits
//   out_last      this number is the final one of the file
//   done          sticky: file fully parsed and final number (if any) consumed
//
// Handshake: a byte moves when in_valid && in_ready, a result moves when
// out_valid && out_ready. in_ready = !done && (!out_valid || out_ready), so a
// new byte may be accepted in the same cycle the held result drains. Once a
// result is presented it and all its side fields stay frozen until taken.
// -----------------------------------------------------------------------------
module ascii_num_parser #(
    parameter int W         = 32,
    parameter int ALLOW_NEG = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_num,
    output logic [7:0]   out_delim,
    output logic         out_overflow,
    output logic         out_last,
    output logic         done
);

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;

    // ------------------------------------------------------------------
    // Parse state
    // ------------------------------------------------------------------
    logic [W-1:0] acc;
    logic         ovf;
    logic         have_digit;
    logic         have_minus;

    logic [W-1:0] acc_d;
    logic         ovf_d;
    logic         have_digit_d;
    logic         have_minus_d;

    // Result produced by the byte accepted this cycle
    logic         emit;
    logic [W-1:0] emit_mag;
    logic [7:0]   emit_delim;
    logic         emit_ovf;
    logic         emit_last;
    logic         file_end;     // in_last consumed with nothing to emit

    // ------------------------------------------------------------------
    // Byte classification and multiply-accumulate
    // ------------------------------------------------------------------
    logic           accept;
    logic           is_digit;
    logic           is_sign;
    logic [W+3:0]   acc_ext;
    logic [W+3:0]   digit_ext;
    logic [W+3:0]   prod;
    logic           prod_ovf;
    logic           out_xfer;

    assign in_ready = !done && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    assign is_digit = (in_data >= ASCII_ZERO) && (in_data <= ASCII_NINE);
    // A '-' only counts as a sign before the first digit; anywhere else it
    // is an ordinary delimiter.
    assign is_sign  = (ALLOW_NEG != 0) && (in_data == ASCII_MINUS) && !have_digit;

    // acc*10 + d as shift-and-add in W+4 bits; the extra 4 bits are enough
    // to hold the largest possible result, so any set bit there is overflow.
    assign acc_ext   = {4'b0000, acc};
    assign digit_ext = {{W{1'b0}}, in_data[3:0]};
    assign prod      = (acc_ext << 3) + (acc_ext << 1) + digit_ext;
    assign prod_ovf  = |prod[W+3:W];

    // ------------------------------------------------------------------
    // Next parse state and result generation
    // ------------------------------------------------------------------
    always_comb begin
        acc_d        = acc;
        ovf_d        = ovf;
        have_digit_d = have_digit;
        have_minus_d = have_minus;
        emit         = 1'b0;
        emit_mag     = acc;
        emit_delim   = in_data;
        emit_ovf     = ovf;
        emit_last    = in_last;
        file_end     = 1'b0;

        if (accept) begin
            if (is_digit) begin
                if (in_last) begin
                    // Fold the digit in and close the number at once.
                    emit         = 1'b1;
                    emit_mag     = prod[W-1:0];
                    emit_delim   = 8'h00;
                    emit_ovf     = ovf || prod_ovf;
                    emit_last    = 1'b1;
                    acc_d        = '0;
                    ovf_d        = 1'b0;
                    have_digit_d = 1'b0;
                    have_minus_d = 1'b0;
                end else begin
                    acc_d        = prod[W-1:0];
                    ovf_d        = ovf || prod_ovf;
                    have_digit_d = 1'b1;
                end
            end else if (is_sign) begin
                have_minus_d = 1'b1;
                file_end     = in_last;
            end else if (have_digit) begin
                emit         = 1'b1;
                emit_mag     = acc;
                emit_delim   = in_data;
                emit_ovf     = ovf;
                emit_last    = in_last;
                acc_d        = '0;
                ovf_d        = 1'b0;
                have_digit_d = 1'b0;
                have_minus_d = 1'b0;
            end else begin
                // Delimiter with no pending number: swallowed, and any
                // dangling sign is forgotten.
                have_minus_d = 1'b0;
                file_end     = in_last;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc        <= '0;
            ovf        <= 1'b0;
            have_digit <= 1'b0;
            have_minus <= 1'b0;
        end else begin
            acc        <= acc_d;
            ovf        <= ovf_d;
            have_digit <= have_digit_d;
            have_minus <= have_minus_d;
        end
    end

    // ------------------------------------------------------------------
    // Output register and sticky done
    // ------------------------------------------------------------------
    logic [W-1:0] emit_num;

    assign emit_num = have_minus ? ({W{1'b0}} - emit_mag) : emit_mag;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_num      <= '0;
            out_delim    <= 8'h00;
            out_overflow <= 1'b0;
            out_last     <= 1'b0;
        end else if (emit) begin
            // emit implies in_ready, so any held result drains this cycle.
            out_valid    <= 1'b1;
            out_num      <= emit_num;
            out_delim    <= emit_delim;
            out_overflow <= emit_ovf;
            out_last     <= emit_last;
        end else if (out_xfer) begin
            out_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
        end else if (file_end || (out_xfer && out_last)) begin
            done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ascii_num_parser.sv
// Bench for ascii_num_parser. Two instances share one input stream: one with
// signed parsing enabled, one without. Each has its own reference model that
// turns the accepted byte stream into expected results (digit string to
// integer arithmetic), pushed into a queue and popped by a monitor.
module tb_ascii_num_parser;

    localparam int W  = 32;
    localparam int EW = W + 10;   // {num, delim, ovf, last}
    localparam longint unsigned TWO_W = 64'd1 << W;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic         in_valid = 1'b0;
    logic [7:0]   in_data  = 8'h00;
    logic         in_last  = 1'b0;
    logic         out_ready = 1'b1;

    logic         in_ready_a, out_valid_a, out_overflow_a, out_last_a, done_a;
    logic [W-1:0] out_num_a;
    logic [7:0]   out_delim_a;
    logic         in_ready_n, out_valid_n, out_overflow_n, out_last_n, done_n;
    logic [W-1:0] out_num_n;
    logic [7:0]   out_delim_n;

    ascii_num_parser #(.W(W), .ALLOW_NEG(1)) dut_a (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_num(out_num_a),
        .out_delim(out_delim_a), .out_overflow(out_overflow_a), .out_last(out_last_a),
        .done(done_a)
    );

    ascii_num_parser #(.W(W), .ALLOW_NEG(0)) dut_n (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_num(out_num_n),
        .out_delim(out_delim_n), .out_overflow(out_overflow_n), .out_last(out_last_n),
        .done(done_n)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [EW-1:0] exp_q_a[$];
    logic [EW-1:0] exp_q_n[$];
    int n_vec = 0;
    int n_bad = 0;
    int stall_cnt = 0;
    bit rand_ready = 1'b0;
    bit gap_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: event did not occur within its cycle budget at %0t", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: digits are collected as text and converted when the
    // number closes. Index 0 = signed instance, 1 = unsigned instance.
    // ------------------------------------------------------------------
    string m_str[2];
    bit    m_min[2];

    task automatic model_emit(input int k, input logic [7:0] delim, input bit last);
        longint unsigned low, exact, num;
        bit big;
        int d;
        low = 0; exact = 0; big = 1'b0;
        for (int i = 0; i < m_str[k].len(); i++) begin
            d = int'(m_str[k][i]) - 48;
            low = (low * 10 + longint'(d)) % TWO_W;
            if (!big) begin
                exact = exact * 10 + longint'(d);
                if (exact >= TWO_W) big = 1'b1;
            end
        end
        num = m_min[k] ? ((TWO_W - low) % TWO_W) : low;
        if (k == 0) exp_q_a.push_back({num[W-1:0], delim, big, last});
        else        exp_q_n.push_back({num[W-1:0], delim, big, last});
        m_str[k] = "";
        m_min[k] = 1'b0;
    endtask

    task automatic model_step(input int k, input logic [7:0] b, input bit last);
        if (b >= 8'h30 && b <= 8'h39) begin
            m_str[k] = $sformatf("%s%c", m_str[k], b);
            if (last) model_emit(k, 8'h00, 1'b1);
        end else if (k == 0 && b == 8'h2D && m_str[k].len() == 0) begin
            m_min[k] = 1'b1;
        end else if (m_str[k].len() > 0) begin
            model_emit(k, b, last);
        end else begin
            m_min[k] = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (inputs change 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b, input bit last);
        bit ok_a, ok_n;
        int cyc;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            @(posedge clock); #1;
        end
        in_valid = 1'b1; in_data = b; in_last = last;
        cyc = 0;
        forever begin
            @(negedge clock);
            ok_a = in_ready_a;
            ok_n = in_ready_n;
            if (!ok_a) stall_cnt++;
            @(posedge clock); #1;
            if (ok_a != ok_n) check("in_ready_agree", {63'd0, ok_a}, {63'd0, ok_n});
            if (ok_a) model_step(0, b, last);
            if (ok_n) model_step(1, b, last);
            if (ok_a || ok_n) break;
            cyc++;
            if (cyc > 60) begin
                fail_now("in_ready_wait");
                break;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last_on_final);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], last_on_final && (i == s.len() - 1));
    endtask

    task automatic clear_model();
        exp_q_a.delete();
        exp_q_n.delete();
        for (int k = 0; k < 2; k++) begin
            m_str[k] = "";
            m_min[k] = 1'b0;
        end
    endtask

    // Reset lands mid-cycle, away from any clock edge, and outputs are
    // checked before the next edge to see the asynchronous clear.
    task automatic do_reset();
        #2 reset = 1'b1;
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        check("reset_a", {out_valid_a, out_num_a, out_delim_a, out_overflow_a, out_last_a, done_a}, 64'd0);
        check("reset_n", {out_valid_n, out_num_n, out_delim_n, out_overflow_n, out_last_n, done_n}, 64'd0);
        clear_model();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        for (cyc = 0; cyc < 300; cyc++) begin
            @(negedge clock);
            if (exp_q_a.size() == 0 && exp_q_n.size() == 0 && !out_valid_a && !out_valid_n) break;
        end
        if (cyc >= 300) fail_now("drain");
        @(posedge clock); #1;
    endtask

    task automatic finish_file();
        drain();
        @(negedge clock);
        check("done_a", {63'd0, done_a}, 64'd1);
        check("done_n", {63'd0, done_n}, 64'd1);
        check("in_ready_after_done", {62'd0, in_ready_a, in_ready_n}, 64'd0);
        @(posedge clock); #1;
    endtask

    // Random consumer back-pressure
    always begin
        @(posedge clock); #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    bit            hold_p[2];
    logic [EW-1:0] hold_w[2];
    bit            done_p[2];

    task automatic mon_step(input int k, input logic ov, input logic [EW-1:0] word, input logic dn);
        logic [EW-1:0] exp;
        string sfx;
        sfx = (k == 0) ? "signed" : "unsigned";
        if (reset) begin
            hold_p[k] = 1'b0;
            done_p[k] = 1'b0;
            return;
        end
        if (done_p[k]) check($sformatf("done_after_last_%s", sfx), {63'd0, dn}, 64'd1);
        done_p[k] = 1'b0;
        if (hold_p[k]) check($sformatf("hold_%s", sfx), {21'd0, ov, word}, {21'd0, 1'b1, hold_w[k]});
        hold_p[k] = 1'b0;
        if (ov && out_ready) begin
            if ((k == 0 && exp_q_a.size() == 0) || (k == 1 && exp_q_n.size() == 0)) begin
                check($sformatf("unexpected_out_%s", sfx), {22'd0, word}, 64'd0 - 64'd1);
            end else begin
                exp = (k == 0) ? exp_q_a.pop_front() : exp_q_n.pop_front();
                check($sformatf("out_%s", sfx), {22'd0, word}, {22'd0, exp});
                done_p[k] = word[0];
            end
        end else if (ov) begin
            hold_p[k] = 1'b1;
            hold_w[k] = word;
        end
    endtask

    always @(negedge clock) begin
        mon_step(0, out_valid_a, {out_num_a, out_delim_a, out_overflow_a, out_last_a}, done_a);
        mon_step(1, out_valid_n, {out_num_n, out_delim_n, out_overflow_n, out_last_n}, done_n);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        string s;
        int len, r;
        clear_model();
        @(posedge clock); #1;
        do_reset();

        // Two numbers, consumer always ready, never a stall
        out_ready = 1'b1;
        stall_cnt = 0;
        send_str("12,345\n", 1'b0);
        drain();
        check("in_ready_held", 64'(stall_cnt), 64'd0);

        // Repeated delimiters and in_last on a digit
        send_str("7\n\n  42", 1'b1);
        finish_file();

        // Overflow boundary then a clean number
        do_reset();
        send_str("4294967295 4294967296 5 ", 1'b0);
        drain();

        // Sign handling
        do_reset();
        send_str("-15 3-2\n", 1'b0);
        drain();

        // Back-pressure: result held, input stalled
        do_reset();
        out_ready = 1'b0;
        fork
            send_str("9,8,", 1'b0);
            begin
                repeat (6) @(negedge clock);
                check("held_valid", {62'd0, out_valid_a, out_valid_n}, 64'd3);
                check("held_num_a", 64'(out_num_a), 64'd9);
                check("held_num_n", 64'(out_num_n), 64'd9);
                check("held_in_ready", {62'd0, in_ready_a, in_ready_n}, 64'd0);
                @(posedge clock); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with a result pending, then with a partial number
        do_reset();
        out_ready = 1'b0;
        send_str("9,", 1'b0);
        check("pending_before_reset", {62'd0, out_valid_a, out_valid_n}, 64'd3);
        do_reset();
        out_ready = 1'b1;
        send_str("123", 1'b0);
        do_reset();
        send_str("4\n", 1'b1);
        finish_file();

        // Random files with random back-pressure and input gaps
        for (int f = 0; f < 40; f++) begin
            do_reset();
            rand_ready = 1'b1;
            gap_en = 1'b1;
            s = "";
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 21);
                if (r < 11)       s = $sformatf("%s%c", s, 8'h30 + 8'($urandom_range(0, 9)));
                else if (r == 11) s = {s, ","};
                else if (r == 12) s = {s, " "};
                else if (r == 13) s = {s, "\n"};
                else if (r < 17)  s = {s, "-"};
                else if (r == 17) s = {s, "x"};
                else if (r == 18) s = {s, ":"};
                else if (r == 19) s = {s, "9999999999"};
                else              s = $sformatf("%s%c", s, 8'h30 + 8'($urandom_range(0, 9)));
            end
            send_str(s, 1'b1);
            finish_file();
            rand_ready = 1'b0;
            gap_en = 1'b0;
            out_ready = 1'b1;
        end

        check("leftover_a", 64'(exp_q_a.size()), 64'd0);
        check("leftover_n", 64'(exp_q_n.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
